// File: rtl/dm_sba_mem_responder.sv
// Word-organised memory responder for the Debug Module SBA master port, with programmable
// grant/response latency. Optional statistics counters are enabled by DM_SBA_MEM_STATS_EN.
module dm_sba_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned GNT_DELAY   = 0,
   parameter int unsigned RSP_DELAY   = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        slave_req_i,
   input  logic [31:0] slave_add_i,
   input  logic        slave_we_i,
   input  logic [31:0] slave_wdata_i,
   input  logic [3:0]  slave_be_i,
   output logic        slave_gnt_o,
   output logic        slave_r_valid_o,
   output logic        slave_r_err_o,
   output logic        slave_r_other_err_o,
   output logic [31:0] slave_r_rdata_o,
   output logic [15:0] access_cnt_o,
   output logic [15:0] err_cnt_o
);

   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  GNT_LOAD   = 4'(GNT_DELAY - 1);
   // The grant cycle itself counts as one response-delay cycle, hence the -2.
   localparam logic [3:0]  RSP_LOAD   = 4'(RSP_DELAY - 2);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_GNT_WAIT = 2'd1;
   localparam logic [1:0] S_RSP_WAIT = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;
   localparam logic [1:0] S_AFTER_GNT = (RSP_DELAY == 1) ? S_RESP : S_RSP_WAIT;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] add_q, wdata_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic             gnt;
   logic             resp;
   logic [32:0]      diff;
   logic [IDX_W-1:0] idx;
   logic             oor, be0, ok;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (slave_req_i) begin
               if (GNT_DELAY == 0) begin
                  gnt     = 1'b1;
                  state_d = S_AFTER_GNT;
                  cnt_d   = RSP_LOAD;
               end else begin
                  state_d = S_GNT_WAIT;
                  cnt_d   = GNT_LOAD;
               end
            end
         end
         S_GNT_WAIT: begin
            if (!slave_req_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               gnt     = 1'b1;
               state_d = S_AFTER_GNT;
               cnt_d   = RSP_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RSP_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
      if (rst_i) gnt = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (gnt) begin
         add_q   <= slave_add_i;
         we_q    <= slave_we_i;
         wdata_q <= slave_wdata_i;
         be_q    <= slave_be_i;
      end
   end

   // A reset landing on the RESP cycle suppresses both the response and the write.
   assign resp = (state_q == S_RESP) && !rst_i;
   assign diff = {1'b0, add_q} - {1'b0, BASE_ADDR};
   assign oor  = diff[32] || (diff[31:0] >= SPAN_BYTES);
   assign be0  = (be_q == 4'b0000);
   assign ok   = !oor && !be0;
   assign idx  = diff[IDX_W+1:2];

   always_ff @(posedge clk_i) begin
      if (resp && we_q && ok) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign slave_gnt_o         = gnt;
   assign slave_r_valid_o     = resp;
   assign slave_r_err_o       = resp && oor;
   assign slave_r_other_err_o = resp && !oor && be0;
   assign slave_r_rdata_o     = (resp && !we_q && ok) ? mem_q[idx] : 32'h0;

`ifdef DM_SBA_MEM_STATS_EN
   logic [15:0] access_cnt_q, err_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         access_cnt_q <= 16'h0;
         err_cnt_q    <= 16'h0;
      end else begin
         if (gnt && access_cnt_q != 16'hFFFF) access_cnt_q <= access_cnt_q + 16'h1;
         if (resp && !ok && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'h1;
      end
   end

   assign access_cnt_o = access_cnt_q;
   assign err_cnt_o    = err_cnt_q;
`else
   assign access_cnt_o = 16'h0;
   assign err_cnt_o    = 16'h0;
`endif

endmodule
